// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB master bus for apb_master_bridge.
// The master modport is the bridge's view; the slave modport is the view of
// whatever drives commands and plays the APB slave.
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    // command side
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    // response side
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    // APB bus
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB master bridge: turns a valid/ready command into an APB SETUP/ACCESS
// transfer, waits on PREADY with an optional bounded timeout, and returns a
// one-cycle response strobe carrying read data and error/timeout status.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16   // 0 disables the timeout
) (
    input  logic PCLK,
    input  logic PRESETn,
    apb_master_bridge_if.master bus
);

    // Wait counter sized to hold TIMEOUT_CYCLES, never narrower than 1 bit.
    localparam int CW        = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // The abort fires on the edge that ends the TIMEOUT_CYCLES-th stalled
    // ACCESS cycle, i.e. when the counter already holds TIMEOUT_CYCLES-1.
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
    localparam bit   TO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_q;
    logic            accept;
    logic            wait_hit;
    logic            done_ok;
    logic            done_to;

    // A command may be taken in IDLE or in the RESP cycle of the previous
    // transfer, which gives back-to-back transfers a 3-cycle cadence.
    // cmd_ready is gated with PRESETn so it reads 0 while reset is held.
    assign bus.cmd_ready = PRESETn && ((state_q == IDLE) || (state_q == RESP));
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    // APB control and response strobe decode straight from state.
    assign bus.PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.PENABLE   = (state_q == ACCESS);
    assign bus.rsp_valid = (state_q == RESP);

    // Timeout condition; PREADY takes priority over it in the FSM below.
    assign wait_hit = TO_EN && (wait_q >= TO_LAST);

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic and completion qualifiers.
    always_comb begin
        state_d = state_q;
        done_ok = 1'b0;
        done_to = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    done_ok = 1'b1;
                    state_d = RESP;
                end else if (wait_hit) begin
                    done_to = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = accept ? SETUP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Wait counter: counts stalled ACCESS cycles, saturates, clears elsewhere.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_q <= '0;
        end else if (state_q == ACCESS) begin
            if (!bus.PREADY && (wait_q != {CW{1'b1}})) wait_q <= wait_q + 1'b1;
        end else begin
            wait_q <= '0;
        end
    end

    // Address/data latch on accept; held stable through ACCESS and in IDLE.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            bus.PWRITE <= 1'b0;
            bus.PADDR  <= '0;
            bus.PWDATA <= '0;
        end else if (accept) begin
            bus.PWRITE <= bus.cmd_write;
            bus.PADDR  <= bus.cmd_addr;
            bus.PWDATA <= bus.cmd_wdata;
        end
    end

    // Response capture at the end of ACCESS; held until the next completion.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else if (done_ok) begin
            bus.rsp_rdata   <= bus.PWRITE ? '0 : bus.PRDATA;
            bus.rsp_err     <= bus.PSLVERR;
            bus.rsp_timeout <= 1'b0;
        end else if (done_to) begin
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b1;
            bus.rsp_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a response scoreboard and a
// simple configurable APB slave model.
module tb_apb_master_bridge;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic PCLK = 1'b0;
    logic PRESETn;

    always #5 PCLK = ~PCLK;

    apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
        int            n_acc;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   rsp_cnt     = 0;

    // slave model configuration for the current transfer
    int            wait_n    = 0;
    logic [DW-1:0] prd       = '0;
    logic          perr_rdy  = 1'b0;
    logic          perr_wait = 1'b0;
    int            k         = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge PCLK) cyc <= cyc + 1;

    // APB slave: stalls wait_n ACCESS cycles, then answers with prd/perr_rdy.
    initial begin
        bus.PREADY  = 1'b0;
        bus.PRDATA  = '0;
        bus.PSLVERR = 1'b0;
        forever begin
            @(negedge PCLK);
            if (bus.PSEL && bus.PENABLE) k = k + 1;
            else                         k = 0;
            if (k != 0 && k > wait_n) begin
                bus.PREADY  = 1'b1;
                bus.PRDATA  = prd;
                bus.PSLVERR = perr_rdy;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PRDATA  = 32'hBAD0BAD0;
                bus.PSLVERR = (k != 0) ? perr_wait : 1'b0;
            end
        end
    end

    // Bus monitor and scoreboard checker.
    int   acc = 0;
    int   setup_n = 0;
    exp_t e_m;
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            acc     = 0;
            setup_n = 0;
        end else begin
            if (bus.PENABLE) chk("penable_needs_psel", 64'(bus.PSEL), 64'd1);
            if (bus.PSEL && !bus.PENABLE) setup_n++;
            if (bus.PSEL && bus.PENABLE) begin
                acc++;
                if (sb.size() > 0) begin
                    chk("paddr_stable", 64'(bus.PADDR), 64'(sb[0].addr));
                    chk("pwrite", 64'(bus.PWRITE), 64'(sb[0].wr));
                    if (sb[0].wr) chk("pwdata", 64'(bus.PWDATA), 64'(sb[0].wdata));
                end
            end
            if (bus.rsp_valid) begin
                rsp_cnt++;
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 64'd1, 64'd0);
                end else begin
                    e_m = sb.pop_front();
                    chk("rsp_rdata",   64'(bus.rsp_rdata),   64'(e_m.rdata));
                    chk("rsp_err",     64'(bus.rsp_err),     64'(e_m.err));
                    chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e_m.to));
                    chk("access_cycles", 64'(acc), 64'(e_m.n_acc));
                    chk("setup_cycles", 64'(setup_n), 64'd1);
                    chk("psel_in_resp", 64'(bus.PSEL), 64'd0);
                end
                acc     = 0;
                setup_n = 0;
            end
        end
    end

    // Drive one command, wait for acceptance, push its expected response.
    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] er, input logic ee, input logic et,
                        input int na, input bit keep, output int acc_cyc);
        exp_t e;
        bit   ok = 1'b0;
        acc_cyc = -1;
        @(negedge PCLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        for (int i = 0; i < 50; i++) begin
            if (bus.cmd_ready) begin
                @(posedge PCLK);
                ok = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
        if (!ok) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            e.wr = wr; e.addr = a; e.wdata = d;
            e.rdata = er; e.err = ee; e.to = et; e.n_acc = na;
            sb.push_back(e);
        end
        #1;
        acc_cyc = cyc;
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(negedge PCLK);
            #1;
        end
        chk("rsp_arrived", 64'(sb.size()), 64'd0);
    endtask

    int t0, t1, t2, rc;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        PRESETn = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_psel",      64'(bus.PSEL),      64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        chk("rel_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rel_penable",   64'(bus.PENABLE),   64'd0);
        chk("rel_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);

        // write, zero wait
        wait_n = 0; prd = 32'h0; perr_rdy = 0; perr_wait = 0;
        send(1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1, 1'b0, t0);
        wait_idle();

        // read, 3 wait states
        wait_n = 3; prd = 32'h12345678;
        send(1'b0, 8'h24, 32'h0, 32'h12345678, 1'b0, 1'b0, 4, 1'b0, t0);
        wait_idle();

        // slave error on completion
        wait_n = 0; prd = 32'hA5A50030; perr_rdy = 1;
        send(1'b0, 8'h30, 32'h0, 32'hA5A50030, 1'b1, 1'b0, 1, 1'b0, t0);
        wait_idle();
        chk("rsp_err_hold", 64'(bus.rsp_err), 64'd1);

        // PSLVERR during a stalled cycle is ignored
        wait_n = 1; perr_rdy = 0; perr_wait = 1;
        send(1'b0, 8'h30, 32'h0, 32'hA5A50030, 1'b0, 1'b0, 2, 1'b0, t0);
        wait_idle();

        // timeout: PREADY never rises
        wait_n = 1000; perr_wait = 0; prd = 32'hCAFEF00D;
        send(1'b0, 8'h40, 32'h0, 32'h0, 1'b1, 1'b1, TO, 1'b0, t0);
        wait_idle();
        chk("to_psel_after",   64'(bus.PSEL),        64'd0);
        chk("to_timeout_hold", 64'(bus.rsp_timeout), 64'd1);

        // PREADY rises on the last allowed cycle: normal completion
        wait_n = TO - 1;
        send(1'b0, 8'h44, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, TO, 1'b0, t0);
        wait_idle();

        // reset during the 2nd ACCESS cycle of a read
        wait_n = 5; prd = 32'h55AA55AA;
        send(1'b0, 8'h50, 32'h0, 32'h55AA55AA, 1'b0, 1'b0, 6, 1'b0, t0);
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            #1;
            if (k == 2) break;
        end
        chk("reached_access2", 64'(k), 64'd2);
        rc = rsp_cnt;
        PRESETn = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_psel",      64'(bus.PSEL),        64'd0);
        chk("mid_rst_penable",   64'(bus.PENABLE),     64'd0);
        chk("mid_rst_cmd_ready", 64'(bus.cmd_ready),   64'd0);
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid),   64'd0);
        chk("mid_rst_rsp_rdata", 64'(bus.rsp_rdata),   64'd0);
        chk("mid_rst_rsp_err",   64'(bus.rsp_err),     64'd0);
        chk("mid_rst_rsp_to",    64'(bus.rsp_timeout), 64'd0);
        chk("mid_rst_paddr",     64'(bus.PADDR),       64'd0);
        chk("mid_rst_pwrite",    64'(bus.PWRITE),      64'd0);
        chk("mid_rst_pwdata",    64'(bus.PWDATA),      64'd0);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        #1;
        chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(posedge PCLK);
        #1;
        chk("post_rst_cmd_ready2", 64'(bus.cmd_ready), 64'd1);
        chk("post_rst_psel",       64'(bus.PSEL),      64'd0);
        repeat (4) @(negedge PCLK);
        #1;
        chk("no_rsp_after_rst", 64'(rsp_cnt), 64'(rc));

        // back-to-back with cmd_valid held high
        wait_n = 0; prd = 32'h04040404; perr_rdy = 0; perr_wait = 0;
        rc = rsp_cnt;
        send(1'b1, 8'h00, 32'h11111111, 32'h0,        1'b0, 1'b0, 1, 1'b1, t0);
        send(1'b0, 8'h04, 32'h0,        32'h04040404, 1'b0, 1'b0, 1, 1'b1, t1);
        send(1'b1, 8'h08, 32'h88888888, 32'h0,        1'b0, 1'b0, 1, 1'b0, t2);
        wait_idle();
        chk("b2b_gap1",  64'(t1 - t0), 64'd3);
        chk("b2b_gap2",  64'(t2 - t1), 64'd3);
        chk("b2b_count", 64'(rsp_cnt - rc), 64'd3);

        repeat (3) @(negedge PCLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
